seq_detector_param: RTL and testbench

// - Serial bit-stream pattern detector; successor to the fixed 4-bit "1011" Mealy/Moore detectors.
// - Pattern length and reset pattern are parameters; the pattern is runtime-loadable.
// - Runtime overlap/non-overlap mode, Mealy/Moore output style, saturating match counter.
// - Sits on a single-bit serial input path and flags each occurrence of the pattern.

---
 rtl/seq_detector_param.sv | 132 +++++++++++++
 tb/tb_seq_detector_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Serial bit-stream pattern detector. Watches a single-bit input and flags
// every occurrence of a runtime-loadable PAT_LEN-bit pattern (MSB = first bit
// received). Supports overlapping / non-overlapping detection selected at
// runtime, Mealy or Moore output timing selected at build time, and a
// saturating match counter.
//
// Parameters:
//   PAT_LEN  pattern length in bits (>= 2)
//   PATTERN  pattern register value after reset
//   MOORE    0: y follows the completing bit in the same cycle
//            1: y is registered and pulses one cycle later
//   CNT_W    width of match_count
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   x            serial data bit
//   in_valid     x is taken only when high
//   overlap      1: matched bits may start the next match; 0: they may not
//   pat_load     replace the pattern with pat_in (x dropped that cycle)
//   pat_in       new pattern, MSB = first bit
//   count_clr    clear match_count (wins over a simultaneous match)
//   y            match pulse
//   match_count  saturating number of matches
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 MOORE   = 1'b0,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               in_valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               count_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_count
);

  localparam int unsigned        FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0]  FILL_ARM = FILL_W'(PAT_LEN - 1);
  localparam logic [FILL_W-1:0]  FILL_ONE = FILL_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  logic [PAT_LEN-1:0] pat;
  // Only the newest PAT_LEN-1 bits are ever compared (the incoming x supplies
  // the last one), so the oldest history bit is not stored at all.
  logic [PAT_LEN-2:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [CNT_W-1:0]   count;
  logic [PAT_LEN-1:0] window;
  logic               match_now;

  // Candidate window: stored history with the current bit appended as newest.
  assign window = {hist, x};

  // A match needs PAT_LEN-1 eligible history bits plus a valid current bit.
  assign match_now = in_valid & ~pat_load & (fill >= FILL_ARM) & (window == pat);

  // Pattern register, bit history and eligible-bit fill level.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
    end else if (pat_load) begin
      pat  <= pat_in;
      hist <= '0;
      fill <= '0;
    end else if (in_valid) begin
      pat  <= pat;
      hist <= window[PAT_LEN-2:0];
      if (match_now && !overlap) begin
        // Non-overlapping: the bits just consumed may not seed another match.
        fill <= '0;
      end else if (fill < FILL_MAX) begin
        fill <= fill + FILL_ONE;
      end else begin
        fill <= fill;
      end
    end else begin
      pat  <= pat;
      hist <= hist;
      fill <= fill;
    end
  end

  // Saturating match counter; a clear overrides a coincident match.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count_clr) begin
      count <= '0;
    end else if (match_now && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

  assign match_count = count;

  generate
    if (MOORE) begin : g_moore
      logic y_q;

      // Registered pulse one cycle after the completing bit. A pat_load in
      // that next cycle does not cancel it; only reset does.
      always_ff @(posedge clk) begin
        if (reset) begin
          y_q <= 1'b0;
        end else begin
          y_q <= match_now;
        end
      end

      assign y = y_q;
    end else begin : g_mealy
      assign y = match_now;
    end
  endgenerate

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Drives three detector builds from shared inputs: Mealy with an 8-bit
// counter, Moore with an 8-bit counter, and Mealy with a 2-bit counter.
// Expected values come from a queue-based model of the detection rules.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic       in_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       count_clr = 1'b0;

  logic       y_mealy, y_moore, y_sat;
  logic [7:0] cnt_mealy, cnt_moore;
  logic [1:0] cnt_sat;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         q[$];          // eligible bits since reset/load/non-overlap match
  logic [3:0] m_pat = 4'b1011;
  int         m_cnt8 = 0;
  int         m_cnt2 = 0;
  bit         m_prev = 1'b0; // registered pulse expected on the Moore build

  // Observed-hit shift registers for directed tests
  logic [31:0] hits_mealy;
  logic [31:0] hits_moore;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .MOORE(1'b0), .CNT_W(8)) dut_mealy (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .count_clr(count_clr),
    .y(y_mealy), .match_count(cnt_mealy));

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .MOORE(1'b1), .CNT_W(8)) dut_moore (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .count_clr(count_clr),
    .y(y_moore), .match_count(cnt_moore));

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .MOORE(1'b0), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .count_clr(count_clr),
    .y(y_sat), .match_count(cnt_sat));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus with model prediction and checks on both sides of the edge.
  task automatic step(input bit xb, input bit v, input bit ov, input bit ld,
                      input logic [3:0] pin, input bit clr, input bit rst);
    bit exp_m;
    int n;
    @(negedge clk);
    x = xb; in_valid = v; overlap = ov; pat_load = ld; pat_in = pin;
    count_clr = clr; reset = rst;

    // A match is the last four eligible bits (three stored plus x) equal to the pattern.
    exp_m = 1'b0;
    n = q.size();
    if (v && !ld && n >= 3) begin
      exp_m = ({q[n-3], q[n-2], q[n-1], xb} == m_pat);
    end

    #1;
    chk("mealy_y", 32'(y_mealy), 32'(exp_m));
    chk("sat_y", 32'(y_sat), 32'(exp_m));
    chk("moore_y_pre", 32'(y_moore), 32'(m_prev));
    hits_mealy = {hits_mealy[30:0], y_mealy};

    @(posedge clk);
    if (rst) begin
      q.delete();
      m_pat = 4'b1011;
      m_cnt8 = 0;
      m_cnt2 = 0;
      m_prev = 1'b0;
    end else begin
      m_prev = exp_m;
      if (ld) begin
        m_pat = pin;
        q.delete();
      end else if (v) begin
        if (exp_m && !ov) begin
          q.delete();
        end else begin
          q.push_back(xb);
          if (q.size() > 3) void'(q.pop_front());
        end
      end
      if (clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (exp_m) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end

    #1;
    chk("cnt_mealy", 32'(cnt_mealy), 32'(m_cnt8));
    chk("cnt_moore", 32'(cnt_moore), 32'(m_cnt8));
    chk("cnt_sat", 32'(cnt_sat), 32'(m_cnt2));
    chk("moore_y_post", 32'(y_moore), 32'(m_prev));
    hits_moore = {hits_moore[30:0], y_moore};
  endtask

  task automatic bit_in(input bit xb, input bit ov);
    step(xb, 1'b1, ov, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
  endtask

  initial begin
    logic [6:0] s1;
    logic [7:0] s3;
    logic [15:0] s_sat;

    // Reset and reset-state check
    do_reset();
    do_reset();
    chk("reset_cnt", 32'(cnt_mealy), 32'd0);
    chk("reset_moore_y", 32'(y_moore), 32'd0);

    // T1: overlapping, 1011011 -> hits on bits 4 and 7
    s1 = 7'b1011011;
    hits_mealy = '0; hits_moore = '0;
    for (int i = 6; i >= 0; i--) bit_in(s1[i], 1'b1);
    chk("T1_hits_mealy", hits_mealy, 32'b0001001);
    chk("T1_hits_moore", hits_moore, 32'b0001001);
    chk("T1_count", 32'(cnt_mealy), 32'd2);

    // T2: same stream, non-overlapping -> bit 4 only
    do_reset();
    hits_mealy = '0; hits_moore = '0;
    for (int i = 6; i >= 0; i--) bit_in(s1[i], 1'b0);
    chk("T2_hits", hits_mealy, 32'b0001000);
    chk("T2_count", 32'(cnt_mealy), 32'd1);

    // T3: non-overlapping, 10111011 -> bits 4 and 8
    do_reset();
    s3 = 8'b10111011;
    hits_mealy = '0;
    for (int i = 7; i >= 0; i--) bit_in(s3[i], 1'b0);
    chk("T3_hits", hits_mealy, 32'b00010001);
    chk("T3_count", 32'(cnt_mealy), 32'd2);

    // T5: gaps between valid bits -> single match on 4th valid bit
    do_reset();
    hits_mealy = '0;
    bit_in(1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    bit_in(1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b1);
    chk("T5_hits", hits_mealy, 32'b000001);
    chk("T5_count", 32'(cnt_mealy), 32'd1);

    // T6a: pat_load mid-stream (x=1 dropped), then 0110 matches after 4 new bits
    do_reset();
    hits_mealy = '0;
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
    bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
    chk("T6_load_hits", hits_mealy, 32'b00000001);

    // T6b: five overlapping matches saturate a 2-bit counter at 3
    do_reset();
    s_sat = 16'b1011011011011011;
    for (int i = 15; i >= 0; i--) bit_in(s_sat[i], 1'b1);
    chk("T6_sat_count", 32'(cnt_sat), 32'd3);
    chk("T6_full_count", 32'(cnt_mealy), 32'd5);

    // T6c: count_clr together with a completing match -> 0
    bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("T6_clr_count", 32'(cnt_mealy), 32'd0);
    chk("T6_clr_sat", 32'(cnt_sat), 32'd0);

    // T6d: reset after 3 bits of 1011 -> final 1 does not match
    do_reset();
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    do_reset();
    hits_mealy = '0;
    bit_in(1'b1, 1'b1);
    chk("T6_reset_mid", hits_mealy, 32'd0);
    chk("T6_reset_cnt", 32'(cnt_mealy), 32'd0);

    // Randomized traffic against the model
    begin
      bit ov;
      ov = 1'b1;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 9) == 0) ov = ~ov;
        step(1'($urandom_range(0, 1)),
             ($urandom_range(0, 99) < 85),
             ov,
             ($urandom_range(0, 24) == 0),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 99) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
